// File: rtl/banyan_capture_seq_pkg.sv
// Shared state encoding and mode constants for the banyan_mem capture sequencer.
package banyan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    FILL      = 2'd2,
    HOLDOFF   = 2'd3
  } seq_state_t;

  localparam logic [1:0] MODE_IMM     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_AUTO    = 2'd2;

  // Reserved mode 3 falls through to immediate fill.
  function automatic logic mode_waits_trig(input logic [1:0] m);
    return (m == MODE_ONESHOT) || (m == MODE_AUTO);
  endfunction

endpackage

// File: rtl/banyan_capture_seq_holdoff_timer.sv
// Loadable down-counter that stops at zero; paces the auto re-arm holdoff.
module holdoff_timer #(
  parameter int HW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [HW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [HW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - HW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/banyan_capture_seq.sv
// Capture sequencer: turns host arm/abort and ext trigger edges into
// banyan_mem reset/run windows, with capture and missed-trigger counters.
module banyan_capture_seq
  import banyan_seq_pkg::*;
#(
  parameter int HW = 16,
  parameter int CW = 16,
  parameter int MW = 8
) (
  input  logic          i_adc_clk,
  input  logic          i_rst,
  input  logic          i_arm,
  input  logic          i_abort,
  input  logic [1:0]    i_mode,
  input  logic [HW-1:0] i_holdoff,
  input  logic          i_ext_trig,
  input  logic          i_data_valid,
  input  logic          i_rollover,
  output logic          o_mem_reset,
  output logic          o_mem_run,
  output logic [1:0]    o_state,
  output logic          o_busy,
  output logic          o_capture_done,
  output logic [CW-1:0] o_capture_count,
  output logic [MW-1:0] o_missed_count
);

  seq_state_t    r_state;
  logic [1:0]    r_mode;
  logic          r_trig_d;
  logic          r_mem_reset;
  logic          r_capture_done;
  logic [CW-1:0] r_capture_count;
  logic [MW-1:0] r_missed_count;

  logic w_trig_edge;
  logic w_fill_done;
  logic w_hold_load;
  logic w_hold_zero;

  assign w_trig_edge = i_ext_trig & ~r_trig_d;
  // The mem_reset cycle belongs to the previous pointer, so a wrap there is stale.
  assign w_fill_done = (r_state == FILL) & i_rollover & ~r_mem_reset & ~i_abort;
  assign w_hold_load = w_fill_done & (r_mode == MODE_AUTO);

  holdoff_timer #(.HW(HW)) u_holdoff (
    .i_clk      (i_adc_clk),
    .i_rst      (i_rst),
    .i_load     (w_hold_load),
    .i_load_val (i_holdoff),
    .i_dec      (r_state == HOLDOFF),
    .o_zero     (w_hold_zero)
  );

  always_ff @(posedge i_adc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_trig_d <= 1'b0;
    end else begin
      r_trig_d <= i_ext_trig;
    end
  end

  always_ff @(posedge i_adc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_mode          <= MODE_IMM;
      r_mem_reset     <= 1'b0;
      r_capture_done  <= 1'b0;
      r_capture_count <= '0;
    end else begin
      r_mem_reset    <= 1'b0;
      r_capture_done <= 1'b0;
      if (i_abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_arm) begin
              r_mode <= i_mode;
              if (mode_waits_trig(i_mode)) begin
                r_state <= WAIT_TRIG;
              end else begin
                r_state     <= FILL;
                r_mem_reset <= 1'b1;
              end
            end
          end
          WAIT_TRIG: begin
            if (w_trig_edge) begin
              r_state     <= FILL;
              r_mem_reset <= 1'b1;
            end
          end
          FILL: begin
            if (w_fill_done) begin
              r_capture_done  <= 1'b1;
              r_capture_count <= r_capture_count + CW'(1);
              r_state         <= (r_mode == MODE_AUTO) ? HOLDOFF : IDLE;
            end
          end
          HOLDOFF: begin
            if (w_hold_zero) begin
              r_state <= WAIT_TRIG;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_adc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_missed_count <= '0;
    end else if ((r_state == IDLE) && i_arm && !i_abort) begin
      r_missed_count <= '0;
    end else if (w_trig_edge && ((r_state == FILL) || (r_state == HOLDOFF))
                 && (r_missed_count != '1)) begin
      r_missed_count <= r_missed_count + MW'(1);
    end
  end

  assign o_mem_reset     = r_mem_reset;
  assign o_mem_run       = (r_state == FILL) & ~r_mem_reset & i_data_valid;
  assign o_state         = r_state;
  assign o_busy          = (r_state != IDLE);
  assign o_capture_done  = r_capture_done;
  assign o_capture_count = r_capture_count;
  assign o_missed_count  = r_missed_count;

endmodule

// File: tb/tb_banyan_capture_seq.sv
// Directed self-checking bench for banyan_capture_seq, one task per scenario.
module tb_banyan_capture_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, abort, ext_trig, data_valid, rollover;
  logic [1:0]  mode;
  logic [15:0] holdoff;
  logic        mem_reset, mem_run, busy, capture_done;
  logic [1:0]  state;
  logic [15:0] capture_count;
  logic [7:0]  missed_count;

  int checks = 0;
  int errors = 0;
  int expCount = 0;

  always #5 clk = ~clk;

  banyan_capture_seq dut (
    .i_adc_clk       (clk),
    .i_rst           (rst),
    .i_arm           (arm),
    .i_abort         (abort),
    .i_mode          (mode),
    .i_holdoff       (holdoff),
    .i_ext_trig      (ext_trig),
    .i_data_valid    (data_valid),
    .i_rollover      (rollover),
    .o_mem_reset     (mem_reset),
    .o_mem_run       (mem_run),
    .o_state         (state),
    .o_busy          (busy),
    .o_capture_done  (capture_done),
    .o_capture_count (capture_count),
    .o_missed_count  (missed_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 0; abort = 0; ext_trig = 0; data_valid = 0; rollover = 0;
    mode = 2'd0; holdoff = 16'd0;
    tick(); tick();
    checks++;
    if ({state, busy, mem_reset, mem_run, capture_done} !== 6'b0 ||
        capture_count !== 16'd0 || missed_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: state=%0d busy=%b rst=%b run=%b done=%b cnt=%0d miss=%0d, want all 0",
               state, busy, mem_reset, mem_run, capture_done, capture_count, missed_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    int runs = 0;
    mode = 2'd0; data_valid = 1'b1; arm = 1'b1;
    tick(); arm = 1'b0;
    checks++;
    if (state !== 2'd2 || mem_reset !== 1'b1 || mem_run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL imm_start: state=%0d mem_reset=%b mem_run=%b busy=%b, want 2/1/0/1",
               state, mem_reset, mem_run, busy);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (mem_run === 1'b1 && mem_reset === 1'b0) runs++;
    end
    checks++;
    if (runs != 15) begin
      errors++;
      $display("[TB] FAIL imm_run_cycles: got %0d, want 15", runs);
    end
    rollover = 1'b1;
    tick(); rollover = 1'b0;
    expCount++;
    checks++;
    if (capture_done !== 1'b1 || capture_count !== 16'(expCount) || state !== 2'd0 || mem_run !== 1'b0) begin
      errors++;
      $display("[TB] FAIL imm_done: done=%b cnt=%0d state=%0d run=%b, want 1/%0d/0/0",
               capture_done, capture_count, state, mem_run, expCount);
    end
    tick();
    checks++;
    if (capture_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL imm_done_pulse: done=%b, want 0", capture_done);
    end
  endtask

  task automatic test_oneshot();
    int bad = 0;
    mode = 2'd1; arm = 1'b1;
    tick(); arm = 1'b0;
    for (int i = 1; i < 100; i++) begin
      if (state !== 2'd1 || mem_reset !== 1'b0) bad++;
      tick();
    end
    if (state !== 2'd1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL oneshot_wait: %0d cycles left WAIT_TRIG early, want 0", bad);
    end
    ext_trig = 1'b1;
    tick(); ext_trig = 1'b0;
    checks++;
    if (state !== 2'd2 || mem_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oneshot_trig: state=%0d mem_reset=%b, want 2/1", state, mem_reset);
    end
    tick(); tick();
    ext_trig = 1'b1;
    tick(); ext_trig = 1'b0;
    checks++;
    if (missed_count !== 8'd1 || state !== 2'd2) begin
      errors++;
      $display("[TB] FAIL oneshot_missed: missed=%0d state=%0d, want 1/2", missed_count, state);
    end
    rollover = 1'b1;
    tick(); rollover = 1'b0;
    expCount++;
    checks++;
    if (state !== 2'd0 || capture_done !== 1'b1 || capture_count !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL oneshot_end: state=%0d done=%b cnt=%0d, want 0/1/%0d",
               state, capture_done, capture_count, expCount);
    end
  endtask

  task automatic test_auto_rearm();
    int hc;
    mode = 2'd2; holdoff = 16'd10; arm = 1'b1;
    tick(); arm = 1'b0;
    checks++;
    if (state !== 2'd1 || missed_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL auto_arm: state=%0d missed=%0d, want 1/0", state, missed_count);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (20) tick();
      ext_trig = 1'b1;
      tick(); ext_trig = 1'b0;
      repeat (6) tick();
      rollover = 1'b1;
      tick(); rollover = 1'b0;
      expCount++;
      checks++;
      if (state !== 2'd3 || capture_done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL auto_holdoff_entry%0d: state=%0d done=%b, want 3/1", k, state, capture_done);
      end
      hc = 0;
      while (state === 2'd3 && hc < 50) begin
        hc++;
        ext_trig = (k == 0 && hc == 5);
        tick();
      end
      ext_trig = 1'b0;
      checks++;
      if (hc != 11 || state !== 2'd1) begin
        errors++;
        $display("[TB] FAIL auto_holdoff_len%0d: %0d cycles state=%0d, want 11 then 1", k, hc, state);
      end
    end
    checks++;
    if (capture_count !== 16'(expCount) || missed_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL auto_counts: cnt=%0d missed=%0d, want %0d/1", capture_count, missed_count, expCount);
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL auto_abort: state=%0d, want 0", state);
    end
  endtask

  task automatic test_abort();
    mode = 2'd0; data_valid = 1'b1; arm = 1'b1;
    tick(); arm = 1'b0;
    rollover = 1'b1;
    tick(); rollover = 1'b0;
    checks++;
    if (state !== 2'd2 || capture_done !== 1'b0 || capture_count !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL abort_rollover_in_reset: state=%0d done=%b cnt=%0d, want 2/0/%0d",
               state, capture_done, capture_count, expCount);
    end
    tick(); tick();
    checks++;
    if (mem_run !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre_run: mem_run=%b, want 1", mem_run);
    end
    abort = 1'b1; rollover = 1'b1;
    tick(); abort = 1'b0; rollover = 1'b0;
    checks++;
    if (state !== 2'd0 || mem_run !== 1'b0 || capture_done !== 1'b0 || capture_count !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL abort_fill: state=%0d run=%b done=%b cnt=%0d, want 0/0/0/%0d",
               state, mem_run, capture_done, capture_count, expCount);
    end
    rollover = 1'b1;
    tick(); rollover = 1'b0;
    checks++;
    if (capture_count !== 16'(expCount) || capture_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_rollover: cnt=%0d done=%b, want %0d/0", capture_count, capture_done, expCount);
    end
    abort = 1'b1; arm = 1'b1;
    tick(); abort = 1'b0; arm = 1'b0;
    checks++;
    if (state !== 2'd0 || busy !== 1'b0 || mem_reset !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_arm: state=%0d busy=%b mem_reset=%b, want 0/0/0", state, busy, mem_reset);
    end
  endtask

  task automatic test_arm_busy();
    int bad = 0;
    mode = 2'd1; arm = 1'b1;
    tick(); arm = 1'b0;
    mode = 2'd0; arm = 1'b1;
    tick(); arm = 1'b0;
    repeat (3) begin
      if (state !== 2'd1 || mem_reset !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || state !== 2'd1) begin
      errors++;
      $display("[TB] FAIL arm_busy: state=%0d bad=%0d, want 1/0", state, bad);
    end
    ext_trig = 1'b1;
    tick(); ext_trig = 1'b0;
    #1;
    checks++;
    if (state !== 2'd2 || mem_reset !== 1'b1 || mem_run !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arm_busy_trig: state=%0d mem_reset=%b run=%b, want 2/1/0", state, mem_reset, mem_run);
    end
    tick();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      data_valid = i[0];
      #1;
      if (mem_run !== data_valid) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL run_mirror: %0d cycles mem_run differed from data_valid, want 0", bad);
    end
    rollover = 1'b1;
    tick(); rollover = 1'b0;
    expCount++;
    data_valid = 1'b1;
    checks++;
    if (state !== 2'd0 || capture_count !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL arm_busy_end: state=%0d cnt=%0d, want 0/%0d", state, capture_count, expCount);
    end
  endtask

  task automatic test_async_reset_and_saturation();
    mode = 2'd0; arm = 1'b1;
    tick(); arm = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || mem_run !== 1'b0 || mem_reset !== 1'b0 || busy !== 1'b0 ||
        capture_count !== 16'd0 || missed_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: state=%0d run=%b rst=%b busy=%b cnt=%0d miss=%0d, want all 0",
               state, mem_run, mem_reset, busy, capture_count, missed_count);
    end
    tick(); rst = 1'b0;
    tick();
    expCount = 0;
    mode = 2'd2; holdoff = 16'd1000; arm = 1'b1;
    tick(); arm = 1'b0;
    ext_trig = 1'b1;
    tick(); ext_trig = 1'b0;
    tick();
    rollover = 1'b1;
    tick(); rollover = 1'b0;
    expCount++;
    checks++;
    if (state !== 2'd3 || capture_count !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL sat_entry: state=%0d cnt=%0d, want 3/%0d", state, capture_count, expCount);
    end
    for (int i = 0; i < 255; i++) begin
      ext_trig = 1'b1; tick(); ext_trig = 1'b0; tick();
    end
    checks++;
    if (missed_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_reach: missed=%0d, want 255", missed_count);
    end
    for (int i = 0; i < 45; i++) begin
      ext_trig = 1'b1; tick(); ext_trig = 1'b0; tick();
    end
    checks++;
    if (missed_count !== 8'd255 || state !== 2'd3) begin
      errors++;
      $display("[TB] FAIL sat_hold: missed=%0d state=%0d, want 255/3", missed_count, state);
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_oneshot();
    test_auto_rearm();
    test_abort();
    test_arm_busy();
    test_async_reset_and_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
